dmem_responder: RTL and testbench

Data-memory responder for the wolv-z1 core: the target end of the `mem_in_type`/`mem_out_type` data interface that the decode stage drives through `dmem_in`. Accepts single-beat load/store/fence requests and holds a word-addressed on-chip RAM with byte-lane writes. Returns `mem_ready`/`mem_rdata` after a fixed, parameterised latency. Supports one outstanding request and flags protocol violations.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_ram.sv | 35 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response bundles and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_responder_pkg;

    // Request bundle driven by the core's decode stage.
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    // Response bundle returned to the core.
    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dmem_state_type;

    // Wide enough to hold LATENCY-2 for the largest legal LATENCY of 16.
    localparam int DMEM_CNT_W = $clog2(16);

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-lane writes and a registered read port.
// Latency: read data valid the cycle after an enabled read (wstrb == 0).
// Backpressure: none; one access per enabled cycle, writes leave rdata unchanged.
//
// Ports: clock; en (access strobe); wstrb (byte lanes, 0 = read);
//        addr (word index); wdata (write data); rdata (registered read data).
module dmem_ram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic [3:0]            wstrb,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Contents and read register are deliberately not reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (wstrb == 4'b0000) begin
                rdata <= mem[addr];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core: single-beat load/store/fence into on-chip RAM.
// Latency: mem_ready exactly LATENCY cycles after the request cycle (1..16).
// Backpressure: none; requests arriving while BUSY are dropped and set sticky overrun.
//
// Ports: clock; reset (async, active-low); dmem_in (request bundle);
//        dmem_out (mem_ready one-cycle pulse + mem_rdata); overrun (sticky);
//        range_err (pulse with mem_ready for an out-of-range access).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        overrun,
    output logic        range_err
);

    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $fatal(1, "dmem_responder: LATENCY must be in 1..16");
    end

    localparam logic [32:0]           RAM_BYTES = 33'(4) << DEPTH_LOG2;
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT  = DMEM_CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    dmem_state_type          state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        fence_q;

    logic        ready_q, rd_sel_q;
    logic [31:0] ram_rdata;

    logic        accept, complete;
    logic [31:0] cur_addr, cur_wdata, off;
    logic [3:0]  cur_wstrb;
    logic        cur_fence, in_range, ram_en;

    assign accept = (state_q == IDLE) && dmem_in.mem_valid;

    // With LATENCY=1 the access finishes on the accept edge, so the live request
    // feeds the RAM directly; otherwise the latched copy does.
    assign complete  = (LATENCY == 1) ? accept : ((state_q == BUSY) && (cnt_q == '0));
    assign cur_addr  = (LATENCY == 1) ? dmem_in.mem_addr  : addr_q;
    assign cur_wdata = (LATENCY == 1) ? dmem_in.mem_wdata : wdata_q;
    assign cur_wstrb = (LATENCY == 1) ? dmem_in.mem_wstrb : wstrb_q;
    assign cur_fence = (LATENCY == 1) ? dmem_in.mem_fence : fence_q;

    // Offset is compared in 33 bits so the RAM size itself can't wrap.
    assign off      = cur_addr - BASE_ADDR;
    assign in_range = (cur_addr >= BASE_ADDR) && ({1'b0, off} < RAM_BYTES);
    assign ram_en   = complete && !cur_fence && in_range;

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .wstrb (cur_wstrb),
        .addr  (off[DEPTH_LOG2+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && (LATENCY > 1)) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            fence_q   <= 1'b0;
            ready_q   <= 1'b0;
            rd_sel_q  <= 1'b0;
            range_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= dmem_in.mem_addr;
                wdata_q <= dmem_in.mem_wdata;
                wstrb_q <= dmem_in.mem_wstrb;
                fence_q <= dmem_in.mem_fence;
            end
            ready_q   <= complete;
            // RAM output only reaches mem_rdata for a real in-range read.
            rd_sel_q  <= ram_en && (cur_wstrb == 4'b0000);
            range_err <= complete && !cur_fence && !in_range;
            if ((state_q == BUSY) && dmem_in.mem_valid) begin
                overrun <= 1'b1;
            end
        end
    end

    assign dmem_out.mem_ready = ready_q;
    assign dmem_out.mem_rdata = rd_sel_q ? ram_rdata : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{dmem_in.mem_instr, off[1:0], off[31:DEPTH_LOG2+2]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 1, 4 and 3.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n [3];
    mem_in_type  din   [3];
    mem_out_type dout  [3];
    logic        ovr   [3];
    logic        rerr  [3];

    int n_vec = 0;
    int n_bad = 0;

    dmem_responder #(.LATENCY(1)) u_l1 (
        .clock(clock), .reset(rst_n[0]), .dmem_in(din[0]), .dmem_out(dout[0]),
        .overrun(ovr[0]), .range_err(rerr[0]));
    dmem_responder #(.LATENCY(4)) u_l4 (
        .clock(clock), .reset(rst_n[1]), .dmem_in(din[1]), .dmem_out(dout[1]),
        .overrun(ovr[1]), .range_err(rerr[1]));
    dmem_responder #(.LATENCY(3)) u_l3 (
        .clock(clock), .reset(rst_n[2]), .dmem_in(din[2]), .dmem_out(dout[2]),
        .overrun(ovr[2]), .range_err(rerr[2]));

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns 1 time unit after the accept edge.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic f);
        din[d] = '{mem_valid: 1'b1, mem_fence: f, mem_instr: 1'b0,
                   mem_addr: a, mem_wdata: wd, mem_wstrb: ws};
        @(posedge clock); #1;
        din[d].mem_valid = 1'b0;
    endtask

    // Counts cycles after the request cycle until mem_ready; ends on the
    // falling edge of the ready cycle. lat = -1 on timeout.
    task automatic wait_ready(input int d, output int lat, output logic [31:0] rd,
                              output logic re);
        lat = 1; rd = '0; re = 1'b0;
        while (1'b1) begin
            @(negedge clock);
            if (dout[d].mem_ready) begin
                rd = dout[d].mem_rdata;
                re = rerr[d];
                break;
            end
            if (lat >= 20) begin
                lat = -1;
                break;
            end
            lat++;
            @(posedge clock); #1;
        end
    endtask

    task automatic txn(input string tag, input int d, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, input logic f,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_re);
        int          lat;
        logic [31:0] rd;
        logic        re;
        issue(d, a, wd, ws, f);
        wait_ready(d, lat, rd, re);
        check_vec({tag, "/lat"},   32'(lat), 32'(exp_lat));
        check_vec({tag, "/rdata"}, rd, exp_rd);
        check_vec({tag, "/rerr"},  {31'h0, re}, {31'h0, exp_re});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            din[i]   = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        check_vec("rst/ready",  {31'h0, dout[0].mem_ready}, 32'h0);
        check_vec("rst/rdata",  dout[0].mem_rdata, 32'h0);
        check_vec("rst/ovr",    {31'h0, ovr[0]}, 32'h0);
        check_vec("rst/rerr",   {31'h0, rerr[0]}, 32'h0);
        check_vec("rst/ready4", {31'h0, dout[1].mem_ready}, 32'h0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // ---- LATENCY = 1 ----
        txn("l1_wr", 0, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1, 32'h0, 1'b0);
        txn("l1_rd", 0, 32'h0001_0010, 32'h0, 4'h0, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        txn("byte_wr1", 0, 32'h0001_0020, 32'h1122_3344, 4'hF, 1'b0, 1, 32'h0, 1'b0);
        txn("byte_wr2", 0, 32'h0001_0020, 32'hAABB_CCDD, 4'b0100, 1'b0, 1, 32'h0, 1'b0);
        txn("byte_rd", 0, 32'h0001_0023, 32'h0, 4'h0, 1'b0, 1, 32'h11BB_3344, 1'b0);
        txn("fence", 0, 32'h0001_0020, 32'h0, 4'h0, 1'b1, 1, 32'h0, 1'b0);
        txn("w0_wr", 0, 32'h0001_0000, 32'h1234_5678, 4'hF, 1'b0, 1, 32'h0, 1'b0);
        txn("last_wr", 0, 32'h0001_3FFC, 32'h8765_4321, 4'hF, 1'b0, 1, 32'h0, 1'b0);
        txn("last_rd", 0, 32'h0001_3FFC, 32'h0, 4'h0, 1'b0, 1, 32'h8765_4321, 1'b0);
        txn("oor_rd", 0, 32'h0000_FFFC, 32'h0, 4'h0, 1'b0, 1, 32'h0, 1'b1);
        idle(1);
        @(negedge clock);
        check_vec("oor/pulse", {31'h0, rerr[0]}, 32'h0);
        check_vec("oor/ready", {31'h0, dout[0].mem_ready}, 32'h0);
        txn("oor_wr", 0, 32'h0001_4000, 32'hCAFE_F00D, 4'hF, 1'b0, 1, 32'h0, 1'b1);
        txn("w0_rd", 0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, 1, 32'h1234_5678, 1'b0);
        txn("ord_wr", 0, 32'h0001_0030, 32'h0F0F_0F0F, 4'hF, 1'b0, 1, 32'h0, 1'b0);
        idle(1);
        txn("ord_rd", 0, 32'h0001_0030, 32'h0, 4'h0, 1'b0, 1, 32'h0F0F_0F0F, 1'b0);

        // ---- LATENCY = 4 ----
        txn("l4_wr", 1, 32'h0001_0004, 32'h0BAD_CAFE, 4'hF, 1'b0, 4, 32'h0, 1'b0);
        txn("l4_b2b", 1, 32'h0001_0004, 32'h0, 4'h0, 1'b0, 4, 32'h0BAD_CAFE, 1'b0);
        idle(1);
        issue(1, 32'h0001_0004, 32'h0, 4'h0, 1'b0);          // cycle T; now in T+1
        @(posedge clock); #1;                                 // T+2
        @(negedge clock);
        check_vec("ovr/before", {31'h0, ovr[1]}, 32'h0);
        din[1] = '{mem_valid: 1'b1, mem_fence: 1'b0, mem_instr: 1'b0,
                   mem_addr: 32'h0001_0004, mem_wdata: 32'hFFFF_FFFF, mem_wstrb: 4'hF};
        @(posedge clock); #1;                                 // T+3
        din[1].mem_valid = 1'b0;
        @(negedge clock);
        check_vec("ovr/set",   {31'h0, ovr[1]}, 32'h1);
        check_vec("ovr/early", {31'h0, dout[1].mem_ready}, 32'h0);
        @(posedge clock); #1;                                 // T+4
        @(negedge clock);
        check_vec("ovr/ready", {31'h0, dout[1].mem_ready}, 32'h1);
        check_vec("ovr/rdata", dout[1].mem_rdata, 32'h0BAD_CAFE);
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (dout[1].mem_ready) seen++;
        end
        check_vec("ovr/dropped", 32'(seen), 32'h0);
        txn("ovr_rd", 1, 32'h0001_0004, 32'h0, 4'h0, 1'b0, 4, 32'h0BAD_CAFE, 1'b0);
        check_vec("ovr/sticky", {31'h0, ovr[1]}, 32'h1);

        // ---- LATENCY = 3, reset mid-flight ----
        txn("l3_wr", 2, 32'h0001_0000, 32'h0102_0304, 4'hF, 1'b0, 3, 32'h0, 1'b0);
        idle(1);
        issue(2, 32'h0001_0000, 32'h5A5A_5A5A, 4'hF, 1'b0);  // now in T+1
        rst_n[2] = 1'b0;
        @(negedge clock);
        check_vec("mid/ready", {31'h0, dout[2].mem_ready}, 32'h0);
        check_vec("mid/rdata", dout[2].mem_rdata, 32'h0);
        check_vec("mid/rerr",  {31'h0, rerr[2]}, 32'h0);
        check_vec("mid/ovr",   {31'h0, ovr[2]}, 32'h0);
        @(posedge clock); #1;
        rst_n[2] = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (dout[2].mem_ready) seen++;
        end
        check_vec("mid/noresp", 32'(seen), 32'h0);
        txn("mid_rd", 2, 32'h0001_0000, 32'h0, 4'h0, 1'b0, 3, 32'h0102_0304, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
